// File: rtl/dphy_tx_pkg.sv
// -----------------------------------------------------------------------------
// dphy_tx_pkg
//   Shared definitions for the D-PHY transmit sequencers. It holds the lane
//   state encoding, the HS sync byte, the LP line-level pairs and small
//   parameter helpers.
//
//   The states are plain localparam codes rather than an enum. This keeps
//   the encoding fixed for older code that compares raw state values.
//
//   LP level constants are packed as {Dp, Dn}.
// -----------------------------------------------------------------------------
package dphy_tx_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_STOP  = 3'd0;
    localparam tx_state_t ST_LPX   = 3'd1;
    localparam tx_state_t ST_PREP  = 3'd2;
    localparam tx_state_t ST_ZERO  = 3'd3;
    localparam tx_state_t ST_SYNC  = 3'd4;
    localparam tx_state_t ST_DATA  = 3'd5;
    localparam tx_state_t ST_TRAIL = 3'd6;
    localparam tx_state_t ST_EXIT  = 3'd7;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    // A phase length of 0 is treated as 1. Every timed phase therefore
    // occupies at least one byte clock.
    function automatic int clamp_min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hs_tx_sequencer_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   A loadable down-counter that times one protocol phase. It is shared by
//   the data-lane sequencer and the future clock-lane sequencer.
//
//   Ports:
//     clk        in   clock
//     rst_n      in   asynchronous active-low reset; clears the count
//     load       in   load load_value this cycle (the first cycle of a phase)
//     load_value in   W  phase length in cycles (a value of 1 or more)
//     done       out  the current cycle is the last cycle of the phase
//
//   Timing: load_value is loaded on the edge that enters the phase. The
//   phase then lasts load_value cycles. done is high during the last one.
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg > W'(1)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    // A count of 0 only appears after reset. It is treated as expired so
    // that the counter can never wrap around.
    assign done = (count_reg <= W'(1));

endmodule

// File: rtl/hs_tx_sequencer.sv
// -----------------------------------------------------------------------------
// hs_tx_sequencer
//   Byte-clock controller for the HS transmit burst of one D-PHY data lane.
//   It drives the LP line levels and walks the burst sequence:
//     LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11
//   It also feeds the lane serializer and gates the HS DDR stage.
//
//   Ports:
//     TX_byte_clk   in   byte clock
//     TX_rst_n      in   asynchronous active-low reset
//     TxRequestHS   in   burst request; held high for the whole payload
//     TxDataHS      in   8  payload byte (LSB is transmitted first)
//     TxReadyHS     out  byte accepted at this edge if TxRequestHS is high
//     Stopstate     out  lane idle in LP-11 STOP
//     HS_Enable     out  enable for the HS serializer and DDR driver
//     HS_byte       out  8  registered byte to the serializer
//     LP_Dp, LP_Dn  out  LP driver levels
//     HS_burst_cnt  out  16 bursts completed; present only with
//                        TX_BURST_CNT_EN defined
//
//   Optional feature macro: TX_BURST_CNT_EN
//     Adds HS_burst_cnt. The counter counts DATA->TRAIL transitions and
//     wraps at 16 bits.
//
//   All outputs are either registers or decodes of the registered state.
//   No path runs combinationally from an input to an output.
// -----------------------------------------------------------------------------
module hs_tx_sequencer
    import dphy_tx_pkg::*;
#(
    parameter int T_LPX        = 2,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 6,
    parameter int T_HS_TRAIL   = 4,
    parameter int T_HS_EXIT    = 5
) (
    input  logic       TX_byte_clk,
    input  logic       TX_rst_n,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic       Stopstate,
    output logic       HS_Enable,
    output logic [7:0] HS_byte,
    output logic       LP_Dp,
    output logic       LP_Dn
`ifdef TX_BURST_CNT_EN
    ,
    output logic [15:0] HS_burst_cnt
`endif
);

    localparam int LPX_C   = clamp_min1(T_LPX);
    localparam int PREP_C  = clamp_min1(T_HS_PREPARE);
    localparam int ZERO_C  = clamp_min1(T_HS_ZERO);
    localparam int TRAIL_C = clamp_min1(T_HS_TRAIL);
    localparam int EXIT_C  = clamp_min1(T_HS_EXIT);
    localparam int MAX_T   = max2(max2(max2(LPX_C, PREP_C), max2(ZERO_C, TRAIL_C)), EXIT_C);
    localparam int TMR_W   = $clog2(MAX_T) + 1;

    tx_state_t      state_reg;
    tx_state_t      state_next;
    logic [7:0]     hs_byte_reg;
    logic [7:0]     hs_byte_next;
    logic [7:0]     trail_byte;
    logic           timer_load;
    logic [TMR_W-1:0] timer_value;
    logic           timer_done;
    logic [1:0]     lp_lvl;

    // -------------------------------------------------------------------------
    // Phase timer. It is reloaded on every state change, so each timed state
    // starts from its full length.
    // -------------------------------------------------------------------------
    phase_timer #(
        .W (TMR_W)
    ) u_phase_timer (
        .clk        (TX_byte_clk),
        .rst_n      (TX_rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // The trail repeats the inverse of the last bit on the wire. Bytes go out
    // LSB first, so that bit is bit 7 of the byte currently in the register.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_trail
            assign trail_byte[gi] = ~hs_byte_reg[7];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state and next-byte logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        hs_byte_next = hs_byte_reg;

        case (state_reg)
            ST_STOP:  if (TxRequestHS) state_next = ST_LPX;
            ST_LPX:   if (timer_done)  state_next = ST_PREP;
            ST_PREP:  if (timer_done)  state_next = ST_ZERO;
            ST_ZERO:  if (timer_done)  state_next = ST_SYNC;
            ST_SYNC:                   state_next = ST_DATA;
            ST_DATA: begin
                if (TxRequestHS) begin
                    hs_byte_next = TxDataHS;
                end else begin
                    state_next = ST_TRAIL;
                end
            end
            ST_TRAIL: if (timer_done)  state_next = ST_EXIT;
            ST_EXIT:  if (timer_done)  state_next = ST_STOP;
            default:                   state_next = ST_STOP;
        endcase

        // The byte loaded on entry to a state. The register is left alone on
        // entry to DATA. The first DATA cycle therefore still carries the sync
        // byte, and that is the "last byte" of a burst with no payload.
        if (state_next != state_reg) begin
            case (state_next)
                ST_SYNC:  hs_byte_next = SYNC_BYTE;
                ST_TRAIL: hs_byte_next = trail_byte;
                ST_DATA:  hs_byte_next = hs_byte_reg;
                default:  hs_byte_next = 8'h00;
            endcase
        end
    end

    always_comb begin
        timer_load = (state_next != state_reg);
        case (state_next)
            ST_LPX:   timer_value = TMR_W'(LPX_C);
            ST_PREP:  timer_value = TMR_W'(PREP_C);
            ST_ZERO:  timer_value = TMR_W'(ZERO_C);
            ST_TRAIL: timer_value = TMR_W'(TRAIL_C);
            ST_EXIT:  timer_value = TMR_W'(EXIT_C);
            default:  timer_value = TMR_W'(1);
        endcase
    end

    always_ff @(posedge TX_byte_clk or negedge TX_rst_n) begin
        if (!TX_rst_n) begin
            state_reg   <= ST_STOP;
            hs_byte_reg <= 8'h00;
        end else begin
            state_reg   <= state_next;
            hs_byte_reg <= hs_byte_next;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the registered state
    // -------------------------------------------------------------------------
    always_comb begin
        lp_lvl = LP00;
        case (state_reg)
            ST_STOP, ST_EXIT: lp_lvl = LP11;
            ST_LPX:           lp_lvl = LP01;
            default:          lp_lvl = LP00;
        endcase
    end

    assign LP_Dp     = lp_lvl[1];
    assign LP_Dn     = lp_lvl[0];
    assign Stopstate = (state_reg == ST_STOP);
    assign TxReadyHS = (state_reg == ST_DATA);
    assign HS_Enable = (state_reg == ST_ZERO) || (state_reg == ST_SYNC) ||
                       (state_reg == ST_DATA) || (state_reg == ST_TRAIL);
    assign HS_byte   = hs_byte_reg;

`ifdef TX_BURST_CNT_EN
    logic [15:0] burst_cnt_reg;

    always_ff @(posedge TX_byte_clk or negedge TX_rst_n) begin
        if (!TX_rst_n) begin
            burst_cnt_reg <= 16'h0000;
        end else if ((state_reg == ST_DATA) && !TxRequestHS) begin
            burst_cnt_reg <= burst_cnt_reg + 16'd1;
        end
    end

    assign HS_burst_cnt = burst_cnt_reg;
`endif

endmodule

// File: tb/tb_hs_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hs_tx_sequencer
//   Directed bench for hs_tx_sequencer with default parameters. For every
//   clock, the stimulus pushes the outputs expected after the next edge.
//   A monitor pops them shortly after each rising edge and compares them.
// -----------------------------------------------------------------------------
module tb_hs_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [7:0] data;
    logic       TxReadyHS, Stopstate, HS_Enable, LP_Dp, LP_Dn;
    logic [7:0] HS_byte;
`ifdef TX_BURST_CNT_EN
    logic [15:0] HS_burst_cnt;
`endif

    always #5 clk = ~clk;

    hs_tx_sequencer dut (
        .TX_byte_clk (clk),
        .TX_rst_n    (rst_n),
        .TxRequestHS (req),
        .TxDataHS    (data),
        .TxReadyHS   (TxReadyHS),
        .Stopstate   (Stopstate),
        .HS_Enable   (HS_Enable),
        .HS_byte     (HS_byte),
        .LP_Dp       (LP_Dp),
        .LP_Dn       (LP_Dn)
`ifdef TX_BURST_CNT_EN
        ,
        .HS_burst_cnt (HS_burst_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0]  lp;
        logic        stop;
        logic        en;
        logic        rdy;
        logic [7:0]  hb;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc_no   = 0;
    logic [15:0] exp_cnt  = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, expv);
    endtask

    // Monitor: after every rising edge, compare against the next expectation.
    always @(posedge clk) begin
        cyc_no++;
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("lp_stop_en_rdy", {27'd0, LP_Dp, LP_Dn, Stopstate, HS_Enable, TxReadyHS},
                  {27'd0, mon_e.lp, mon_e.stop, mon_e.en, mon_e.rdy});
            check("hs_byte", {24'd0, HS_byte}, {24'd0, mon_e.hb});
`ifdef TX_BURST_CNT_EN
            check("burst_cnt", {16'd0, HS_burst_cnt}, {16'd0, mon_e.cnt});
`endif
            $display("cycle %0d: LP=%b%b stop=%b en=%b rdy=%b byte=%h", cyc_no,
                     LP_Dp, LP_Dn, Stopstate, HS_Enable, TxReadyHS, HS_byte);
        end
    end

    // Drive the inputs for one cycle and queue the outputs expected after the edge.
    task automatic cyc(input logic r, input logic [7:0] d, input logic [1:0] lp,
                       input logic stop, input logic en, input logic rdy, input logic [7:0] hb);
        exp_t e;
        @(negedge clk);
        req  = r;
        data = d;
        e.lp = lp; e.stop = stop; e.en = en; e.rdy = rdy; e.hb = hb; e.cnt = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic stop_cyc(input logic r);
        cyc(r, 8'h00, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    // From STOP, raise the request and expect LPX(2), PREP(3), ZERO(6), SYNC(1)
    // and then the first DATA cycle. In that cycle the sync byte is still held.
    // With drop set, the request is low from PREP onward.
    task automatic preamble(input bit drop);
        logic r;
        r = drop ? 1'b0 : 1'b1;
        cyc(1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(r, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(r, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00);
        cyc(r, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 8'hB8);
        cyc(r, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 8'hB8);
    endtask

    task automatic data_byte(input logic [7:0] b);
        cyc(1'b1, b, 2'b00, 1'b0, 1'b1, 1'b1, b);
    endtask

    // Drop the request in DATA, then expect TRAIL(4), EXIT(5) and one STOP
    // cycle. With keep set, the request is high again from TRAIL onward.
    task automatic tail(input logic [7:0] last, input bit keep);
        logic [7:0] tb_b;
        tb_b = last[7] ? 8'h00 : 8'hFF;
        exp_cnt = exp_cnt + 16'd1;
        cyc(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, tb_b);
        for (int i = 0; i < 3; i++) cyc(keep, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, tb_b);
        for (int i = 0; i < 5; i++) cyc(keep, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00);
        stop_cyc(keep);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {19'd0, LP_Dp, LP_Dn, Stopstate, HS_Enable, TxReadyHS, HS_byte},
              {19'd0, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with the request low.
        repeat (20) stop_cyc(1'b0);

        // Three-byte burst: last byte A5 has bit 7 set, so the trail is 00.
        preamble(1'b0);
        data_byte(8'h12);
        data_byte(8'h34);
        data_byte(8'hA5);
        tail(8'hA5, 1'b0);

        // Last byte 3C has bit 7 clear, so the trail is FF.
        preamble(1'b0);
        data_byte(8'h3C);
        tail(8'h3C, 1'b0);

        // Zero payload: the sync byte is the last byte, so the trail is 00.
        preamble(1'b0);
        tail(8'hB8, 1'b0);

        // Request dropped during PREP: the preamble runs in full and DATA lasts one cycle.
        preamble(1'b1);
        tail(8'hB8, 1'b0);

        // Asynchronous reset in the middle of DATA.
        preamble(1'b0);
        data_byte(8'h55);
        @(negedge clk);
        req  = 1'b1;
        data = 8'h66;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {19'd0, LP_Dp, LP_Dn, Stopstate, HS_Enable, TxReadyHS, HS_byte},
              {19'd0, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00});
        exp_cnt = 16'd0;
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b1;
        repeat (2) stop_cyc(1'b0);

        // Restart from LPX after reset. The request is held across two bursts,
        // with exactly one STOP cycle between them.
        preamble(1'b0);
        data_byte(8'h12);
        tail(8'h12, 1'b1);
        preamble(1'b0);
        data_byte(8'h34);
        tail(8'h34, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
